// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once, one per cycle, then pulses clr_done.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_accept,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    // One spare bit so the count to DEPTH-1 never aliases with a wrapped value.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** ADDR_W) - 1);

    clr_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        clr_accept = 1'b0;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt  = CLEAR;
                    cnt_nxt    = '0;
                    clr_accept = 1'b1;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                clr_en   = 1'b1;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational reads, clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_en;
    logic              clr_accept;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr0_ok;
    logic              wr1_ok;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .clr_accept(clr_accept),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // Writes are blocked for the whole clear, including the cycle the request is taken.
    always_comb begin
        wr0_ok = we0 & ~clr_busy & ~clr_accept;
        wr1_ok = we1 & ~clr_busy & ~clr_accept;
        if (ZERO_REG != 0 && waddr0 == ADDR_W'(ZERO_ADDR)) wr0_ok = 1'b0;
        if (ZERO_REG != 0 && waddr1 == ADDR_W'(ZERO_ADDR)) wr1_ok = 1'b0;
    end

    // Port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0_ok) mem[waddr0] <= wdata0;
            if (wr1_ok) mem[waddr1] <= wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && waddr0 == ra) rv = wdata0;
            if (wr1_ok && waddr1 == ra) rv = wdata1;
`endif
            if (ZERO_REG != 0 && ra == ADDR_W'(ZERO_ADDR)) rv = '0;
        end

        assign rdata[k*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reset, writes, priority, bypass timing and clear engine.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

    logic           clk = 1'b0, reset = 1'b1;
    logic           we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]  waddr0 = '0, waddr1 = '0;
    logic [DW-1:0]  wdata0 = '0, wdata1 = '0;
    logic [NR*AW-1:0] raddr = '0;
    logic [NR*DW-1:0] rdata;
    logic           clr_req = 1'b0;
    logic           clr_busy, clr_done;

    int checks = 0, errors = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got, exp;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd(input int k);
        return rdata[k*DW +: DW];
    endfunction

    task automatic set_ra(input int k, input int a);
        raddr[k*AW +: AW] = AW'(a);
    endtask

    // Drives one write cycle starting just after a negedge; returns at the following negedge.
    task automatic wr2(input logic e0, input int a0, input logic [DW-1:0] d0,
                       input logic e1, input int a1, input logic [DW-1:0] d1);
        we0 = e0; waddr0 = AW'(a0); wdata0 = d0;
        we1 = e1; waddr1 = AW'(a1); wdata1 = d1;
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        if (e0 && a0 != 0) model[a0] = d0;
        if (e1 && a1 != 0) model[a1] = d1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_ra(0, 12); set_ra(1, 31); #1;
        exp_q.push_back('0);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_rd12 got=%h exp=%h", got, exp); end
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
        // Asynchronous reset between edges must clear stored data immediately.
        wr2(1'b1, 5, 32'hCAFE_0005, 1'b1, 9, 32'hCAFE_0009);
        set_ra(0, 5); set_ra(1, 9);
        #2 reset = 1'b1;
        #1;
        exp_q.push_back('0); exp_q.push_back('0);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_rst_rd5 got=%h exp=%h", got, exp); end
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_rst_rd9 got=%h exp=%h", got, exp); end
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++; $display("FAIL async_rst_flags got=%b%b exp=00", clr_busy, clr_done);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        wr2(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0);
        set_ra(0, 5); set_ra(1, 5); #1;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_rd0 got=%h exp=%h", got, exp); end
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_rd1 got=%h exp=%h", got, exp); end
        wr2(1'b1, 0, 32'h1234, 1'b1, 0, 32'h5678);
        set_ra(1, 0); #1;
        exp_q.push_back('0);
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL zero_reg got=%h exp=%h", got, exp); end
    endtask

    task automatic test_conflict;
        wr2(1'b1, 7, 32'h11, 1'b1, 7, 32'h22);
        set_ra(0, 7); #1;
        exp_q.push_back(32'h22);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL conflict_same got=%h exp=%h", got, exp); end
        wr2(1'b1, 8, 32'h88, 1'b1, 9, 32'h99);
        set_ra(0, 8); set_ra(1, 9); #1;
        exp_q.push_back(32'h88); exp_q.push_back(32'h99);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL dual_wr8 got=%h exp=%h", got, exp); end
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL dual_wr9 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_bypass;
        logic [DW-1:0] e3, e4, e6;
`ifdef REGFILE_BYPASS_EN
        e3 = 32'hA5A5; e4 = 32'h2; e6 = 32'h62;
`else
        e3 = '0; e4 = '0; e6 = '0;
`endif
        set_ra(0, 3);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5;
        #2;
        exp_q.push_back(e3);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", got, exp); end
        @(negedge clk);
        we0 = 1'b0; model[3] = 32'hA5A5; #1;
        exp_q.push_back(32'hA5A5);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_next_cycle got=%h exp=%h", got, exp); end
        // Entry 0 stays zero even when a write to it is in flight.
        set_ra(0, 0); set_ra(1, 4);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hBAD;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h2;
        #2;
        exp_q.push_back('0); exp_q.push_back(e4);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_zero got=%h exp=%h", got, exp); end
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_port1 got=%h exp=%h", got, exp); end
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0; model[4] = 32'h2;
        set_ra(1, 6);
        we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h61;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h62;
        #2;
        exp_q.push_back(e6);
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_both got=%h exp=%h", got, exp); end
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0; model[6] = 32'h62; #1;
        exp_q.push_back(32'h62);
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL both_commit got=%h exp=%h", got, exp); end
    endtask

    task automatic test_clear;
        int busy_n, done_n, done_c;
        for (int i = 0; i < 16; i++)
            wr2(1'b1, i, 32'h1000 + i, 1'b1, i + 16, 32'h1000 + i + 16);
        set_ra(0, 5); set_ra(1, 20); #1;
        exp_q.push_back(32'h1005); exp_q.push_back(32'h1014);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fill_rd5 got=%h exp=%h", got, exp); end
        got = rd(1); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fill_rd20 got=%h exp=%h", got, exp); end
        busy_n = 0; done_n = 0; done_c = -1;
        clr_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
            if (clr_busy) busy_n++;
            if (clr_done) begin
                done_n++; done_c = c;
                clr_req = 1'b1;
            end
            if (clr_busy && busy_n == 5) begin
                we0 = 1'b1; waddr0 = 5'd2;  wdata0 = 32'hFF;
                we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'hFF;
            end
            if (clr_busy && busy_n == 20) clr_req = 1'b1;
            if (clr_busy && busy_n == 11) begin
                exp_q.push_back('0); exp_q.push_back(32'h1014);
                got = rd(0); exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin errors++; $display("FAIL mid_clear_rd5 got=%h exp=%h", got, exp); end
                got = rd(1); exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin errors++; $display("FAIL mid_clear_rd20 got=%h exp=%h", got, exp); end
            end
        end
        checks++;
        if (busy_n != 32) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=32", busy_n); end
        checks++;
        if (done_n != 1) begin errors++; $display("FAIL clear_done_pulses got=%0d exp=1", done_n); end
        checks++;
        if (done_c != 32) begin errors++; $display("FAIL clear_done_cycle got=%0d exp=32", done_c); end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int a = 0; a < DEPTH; a++) begin
            set_ra(0, a); #1;
            exp_q.push_back('0);
            got = rd(0); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL cleared_rd%0d got=%h exp=%h", a, got, exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clear;
        int busy_n, done_n;
        bit found;
        wr2(1'b1, 1, 32'h1, 1'b1, 31, 32'hABC);
        set_ra(0, 31);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(32'hABC);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL uncleared_rd31 got=%h exp=%h", got, exp); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", clr_busy); end
        exp_q.push_back('0);
        got = rd(0); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL abort_rd31 got=%h exp=%h", got, exp); end
        @(negedge clk);
        reset = 1'b0;
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (clr_done) done_n++;
        end
        checks++;
        if (done_n != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_n); end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        busy_n = clr_busy ? 1 : 0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (clr_busy) busy_n++;
            if (clr_done) found = 1'b1;
        end
        checks++;
        if (!found || busy_n != 32) begin
            errors++; $display("FAIL reclear got_done=%0d busy=%0d exp_done=1 busy=32", found, busy_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the pipelined CPU datapath. It is the successor to the single-write, dual-read 32x32 file.
- Configurable data width, depth and read-port count.
- Two write ports with a fixed priority rule.
- Optional hardwired-zero entry 0.
- Sequential clear engine that lets software or control zero the file without asserting global reset.
- Optional write-to-read bypass for back-to-back pipeline stages.

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of combinational read ports
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is ordinary storage

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W]
clr_req  in  1  request sequential clear of all entries
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. Assertion immediately zeroes every entry, forces the FSM to IDLE, clr_busy=0, clr_done=0, clear counter=0.
- Reads are combinational. rdata[k] = storage[raddr[k]].
- When ZERO_REG=1 and raddr[k]==0, rdata[k]=0. This holds on every path, including bypass.
- Writes commit on posedge clk when weN=1, subject to these rules:
  - ZERO_REG=1 with waddrN==0: the write is discarded.
  - Both ports enabled with waddr0==waddr1: only wdata1 is written.
  - Different addresses: both are written in the same cycle.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_req=1. Counter loads 0.
  - CLEAR: one entry per cycle, storage[cnt] <= 0, cnt++. clr_busy=1. When cnt==DEPTH-1, that entry is cleared and the FSM goes to DONE. A clear therefore takes exactly DEPTH cycles.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0, then IDLE.
- Clear boundary rules:
  - clr_req while in CLEAR or DONE is ignored (no queueing).
  - External writes are dropped while clr_busy=1, and also in the cycle that clr_req is accepted.
  - Reads during CLEAR return current storage: cleared entries read 0, uncleared entries keep their old value.
  - Counter is ADDR_W+1 bits wide so DEPTH does not wrap prematurely.
  - Reset asserted mid-clear aborts the clear: all entries are 0, the FSM is IDLE, and no clr_done pulse is produced.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address matches an enabled, non-discarded write in the same cycle returns that write's data (write-through forwarding). If both ports match, wdata1 is returned. No bypass while clr_busy=1.
- Undefined: reads always return pre-edge storage, and a same-cycle write becomes visible one cycle later.

Decomposition:
- Package regfile_pkg holds:
  - clear FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2);
  - default DATA_W, ADDR_W and NUM_RD constants;
  - ZERO_ADDR constant.
- One sub-module, regfile_clear_fsm: owns the state register, the counter, clr_busy and clr_done. It outputs clear-enable and clear-address to the storage array.
- Storage, write priority and read muxing stay in regfile_mp, with a generate loop over NUM_RD.

Test Plan:
- Reset then reads: pulse reset asynchronously between edges -> all rdata=0 immediately; clr_busy=0.
- Basic write/read: we0, waddr0=5, wdata0=32'hDEADBEEF; next cycle raddr port0=5 -> rdata port0=32'hDEADBEEF. Write addr 0 with 32'h1234 -> reads 0 (ZERO_REG=1).
- Write conflict: same cycle we0 addr 7 data 32'h11, we1 addr 7 data 32'h22 -> addr 7 reads 32'h22. Different addresses 8 and 9 -> both written.
- Bypass: with REGFILE_BYPASS_EN, write addr 3 = 32'hA5A5 and read addr 3 in the same cycle -> rdata=32'hA5A5 in that cycle. Without the macro -> old value that cycle, 32'hA5A5 the next cycle.
- Clear engine: fill all entries with nonzero values, pulse clr_req -> clr_busy high for 32 cycles; an attempted write of 32'hFF to addr 31 during busy is dropped; clr_done pulses once; all entries read 0 afterwards.
- Reset mid-clear: clr_req, wait 10 cycles, assert reset -> clr_busy=0 immediately, no clr_done, all entries 0, a new clr_req is accepted normally.
